// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - single-port word RAM answering edge-triggered read/write strobes with Ack/Err handshake
// Optional macro RAM_BOUNDS_CHECK_EN: reject requests whose ADDR >= DEPTH instead of wrapping the index.
module ram_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RAM_read_from_RAM,
    input  logic       RAM_write_to_RAM,
    input  logic [9:0] ADDR,
    input  logic [9:0] WDATA,
    output logic [9:0] RDATA,
    output logic       RAMout,
    output logic       Ack,
    output logic       Busy,
    output logic       Err
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t          state, state_nxt;
    logic            rd_q, wr_q;
    logic            rd_edge, wr_edge;
    logic            addr_bad;
    logic [AW-1:0]   addr_q;
    logic            resp_read, resp_err;
    logic            mem_we, latch_addr, load_rdata, nxt_read, nxt_err;
    logic [9:0]      mem [DEPTH];

    assign rd_edge = RAM_read_from_RAM & ~rd_q;
    assign wr_edge = RAM_write_to_RAM & ~wr_q;

`ifdef RAM_BOUNDS_CHECK_EN
    assign addr_bad = ({1'b0, ADDR} >= 11'(DEPTH));
`else
    // Upper address bits are ignored: the index wraps modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDR;
    assign addr_bad       = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        mem_we     = 1'b0;
        latch_addr = 1'b0;
        load_rdata = 1'b0;
        nxt_read   = 1'b0;
        nxt_err    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_edge && wr_edge) begin
                    state_nxt = RESP;
                    nxt_err   = 1'b1;
                end else if (wr_edge) begin
                    state_nxt = RESP;
                    nxt_err   = addr_bad;
                    mem_we    = ~addr_bad;
                end else if (rd_edge) begin
                    if (addr_bad) begin
                        state_nxt = RESP;
                        nxt_err   = 1'b1;
                    end else begin
                        state_nxt  = READ;
                        latch_addr = 1'b1;
                    end
                end
            end
            READ: begin
                state_nxt  = RESP;
                load_rdata = 1'b1;
                nxt_read   = 1'b1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            resp_read <= 1'b0;
            resp_err  <= 1'b0;
            RDATA     <= '0;
        end else begin
            state     <= state_nxt;
            rd_q      <= RAM_read_from_RAM;
            wr_q      <= RAM_write_to_RAM;
            resp_read <= nxt_read;
            resp_err  <= nxt_err;
            if (latch_addr)
                addr_q <= ADDR[AW-1:0];
            if (load_rdata)
                RDATA <= mem[addr_q];
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we && !reset)
            mem[ADDR[AW-1:0]] <= WDATA;
    end

    assign Ack    = (state == RESP);
    assign RAMout = Ack & resp_read;
    assign Err    = Ack & resp_err;
    assign Busy   = (state != IDLE);

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder
module tb_ram_responder;

    typedef struct {
        int         cyc;
        logic       err;
        logic       ramout;
        logic [9:0] rdata;
    } resp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd, wr;
    logic [9:0] addr, wdata;
    logic [9:0] RDATA;
    logic       RAMout, Ack, Busy, Err;

    int    checks   = 0;
    int    failures = 0;
    int    cyc_n    = 0;
    resp_t sb[$];

    ram_responder #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .reset(reset),
        .RAM_read_from_RAM(rd), .RAM_write_to_RAM(wr),
        .ADDR(addr), .WDATA(wdata),
        .RDATA(RDATA), .RAMout(RAMout), .Ack(Ack), .Busy(Busy), .Err(Err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every Ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (Ack === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 expected=0 cycle=%0d", cyc_n);
            end else begin
                resp_t e;
                e = sb.pop_front();
                check("ack_cycle", cyc_n, e.cyc);
                check("ack_err", int'(Err), int'(e.err));
                check("ack_ramout", int'(RAMout), int'(e.ramout));
                check("ack_busy", int'(Busy), 1);
                if (e.ramout)
                    check("ack_rdata", int'(RDATA), int'(e.rdata));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input int at, input logic err, input logic ramout, input logic [9:0] d);
        resp_t e;
        e.cyc = at; e.err = err; e.ramout = ramout; e.rdata = d;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [9:0] d, input int hold, input logic exp_err);
        addr = a; wdata = d; wr = 1'b1;
        expect_resp(cyc_n + 1, exp_err, 1'b0, 10'h0);
        for (int i = 0; i < hold; i++) cyc();
        wr = 1'b0;
        cyc();
    endtask

    task automatic do_read(input logic [9:0] a, input logic [9:0] d);
        addr = a; rd = 1'b1;
        expect_resp(cyc_n + 2, 1'b0, 1'b1, d);
        cyc();
        rd = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) cyc();
        reset = 1'b0;
        check("rst_rdata", int'(RDATA), 0);
        check("rst_ramout", int'(RAMout), 0);
        check("rst_ack", int'(Ack), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_err", int'(Err), 0);

        // write then read back
        do_write(10'd5, 10'h2A5, 1, 1'b0);
        do_read(10'd5, 10'h2A5);

        // held write strobe yields one request
        do_write(10'd3, 10'h011, 4, 1'b0);
        do_read(10'd3, 10'h011);

        // simultaneous strobes: error, no access
        do_write(10'd7, 10'h0C3, 1, 1'b0);
        addr = 10'd7; wdata = 10'h3C0; rd = 1'b1; wr = 1'b1;
        expect_resp(cyc_n + 1, 1'b1, 1'b0, 10'h0);
        cyc();
        rd = 1'b0; wr = 1'b0;
        cyc(); cyc();
        do_read(10'd7, 10'h0C3);

        // write edge while READ is dropped
        do_write(10'd12, 10'h1E1, 1, 1'b0);
        addr = 10'd5; rd = 1'b1;
        expect_resp(cyc_n + 2, 1'b0, 1'b1, 10'h2A5);
        cyc();
        rd = 1'b0; addr = 10'd12; wdata = 10'h000; wr = 1'b1;
        cyc();
        wr = 1'b0;
        cyc(); cyc();
        do_read(10'd12, 10'h1E1);

        // reset during READ aborts without Ack
        addr = 10'd5; rd = 1'b1;
        cyc();
        check("mid_busy", int'(Busy), 1);
        rd = 1'b0; reset = 1'b1;
        cyc();
        check("abort_ack", int'(Ack), 0);
        check("abort_busy", int'(Busy), 0);
        check("abort_ramout", int'(RAMout), 0);
        check("abort_err", int'(Err), 0);
        check("abort_rdata", int'(RDATA), 0);
        reset = 1'b0;
        cyc();
        do_read(10'd5, 10'h2A5);

        // out-of-range address
        do_write(10'd6, 10'h155, 1, 1'b0);
`ifdef RAM_BOUNDS_CHECK_EN
        do_write(10'd70, 10'h3FF, 1, 1'b1);
        do_read(10'd6, 10'h155);
`else
        do_write(10'd70, 10'h3FF, 1, 1'b0);
        do_read(10'd6, 10'h3FF);
`endif

        // back-to-back write/read of the same word
        do_write(10'd20, 10'h2B6, 1, 1'b0);
        do_read(10'd20, 10'h2B6);

        // strobe high across reset release counts as a new edge
        reset = 1'b1; addr = 10'd9; wdata = 10'h099; wr = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        expect_resp(cyc_n + 1, 1'b0, 1'b0, 10'h0);
        cyc();
        wr = 1'b0;
        cyc();
        do_read(10'd9, 10'h099);

        repeat (4) cyc();
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
